univ_shift_reg: RTL and testbench

- Parametrised universal shift register; next generation of the 4-bit load/shift-right block.
- Adds width generalisation, bidirectional shifting, per-word shift counting and a drained/done indication for serializer use.
- Sits between parallel datapaths and serial links, acting as a parallel-to-serial or serial-to-parallel converter in either bit order.

---
 rtl/univ_shift_reg.sv | 81 ++++++++
 tb/tb_univ_shift_reg.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register.
// Parallel load, shift right or left, a per-word shift counter
// that saturates at WIDTH, a drained flag and a one-cycle done pulse.
// Optional rotate mode is built when UNIV_SHIFT_ROTATE_EN is defined.
module univ_shift_reg #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int               CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  logic [WIDTH-1:0] d,
  input  logic             si_r,
  input  logic             si_l,
`ifdef UNIV_SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic [CW-1:0]    cnt,
  output logic             drained,
  output logic             done
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             in_r, in_l;

  // Next-state: load beats shift; otherwise hold. done is only raised
  // by the shift that takes the count from WIDTH-1 to WIDTH.
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    in_r   = si_r;
    in_l   = si_l;
`ifdef UNIV_SHIFT_ROTATE_EN
    // Rotation feeds back the bit that is leaving the register.
    if (rot) begin
      in_r = q_q[0];
      in_l = q_q[WIDTH-1];
    end
`endif
    if (load) begin
      q_d   = d;
      cnt_d = '0;
    end else if (shift) begin
      q_d = dir ? {q_q[WIDTH-2:0], in_l} : {in_r, q_q[WIDTH-1:1]};
      if (cnt_q < CNT_MAX)
        cnt_d = cnt_q + CW'(1);
      done_d = (cnt_q == CNT_LAST);
    end
  end

  // State registers with synchronous reset overriding load/shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q       = q_q;
  assign cnt     = cnt_q;
  assign done    = done_q;
  assign drained = (cnt_q == CNT_MAX);
  assign so      = dir ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
// Rotate vectors are included when UNIV_SHIFT_ROTATE_EN is defined.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, load, shift, dir, si_r, si_l;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         so, drained, done;
  logic [3:0]   cnt;
`ifdef UNIV_SHIFT_ROTATE_EN
  logic         rot;
`endif

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .load(load), .shift(shift), .dir(dir),
    .d(d), .si_r(si_r), .si_l(si_l),
`ifdef UNIV_SHIFT_ROTATE_EN
    .rot(rot),
`endif
    .q(q), .so(so), .cnt(cnt), .drained(drained), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; load = 1'b0; shift = 1'b0;
  endtask

  initial begin
    dir = 1'b0; si_r = 1'b0; si_l = 1'b0; d = '0;
`ifdef UNIV_SHIFT_ROTATE_EN
    rot = 1'b0;
`endif
    // Reset wins over simultaneous load and shift.
    rst = 1'b1; load = 1'b1; shift = 1'b1; d = 8'h11;
    cyc(); cyc();
    chk("rst_q", q, 8'hA5);
    chk("rst_cnt", cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_drained", drained, 0);
    chk("rst_so", so, 1);

    // Load 1011_0010 then 8 right shifts; so shows LSB-first bits.
    idle(); load = 1'b1; d = 8'b1011_0010; cyc();
    chk("ld_q", q, 8'hB2);
    begin
      logic [7:0] exp_so;
      exp_so = 8'b1011_0010;
      load = 1'b0; shift = 1'b1; dir = 1'b0; si_r = 1'b0;
      for (int i = 1; i <= 8; i++) begin
        chk($sformatf("sr_so%0d", i), so, exp_so[i-1]);
        cyc();
        chk($sformatf("sr_done%0d", i), done, (i == 8) ? 1 : 0);
        chk($sformatf("sr_cnt%0d", i), cnt, i);
      end
    end
    chk("sr_q", q, 8'h00);
    chk("sr_drained", drained, 1);
    idle(); cyc();
    chk("hold_done", done, 0);
    chk("hold_cnt", cnt, 8);

    // Left then right shifts, direction-agnostic counting.
    load = 1'b1; d = 8'h81; cyc();
    load = 1'b0; shift = 1'b1; dir = 1'b1; si_l = 1'b1;
    chk("l_so_msb", so, 1);
    cyc(); chk("l1_q", q, 8'h03);
    cyc(); cyc();
    chk("l3_q", q, 8'h0F);
    chk("l3_cnt", cnt, 3);
    dir = 1'b0; si_r = 1'b0;
    cyc(); chk("r1_done", done, 0);
    cyc();
    chk("r2_q", q, 8'h03);
    chk("r2_cnt", cnt, 5);
    chk("r2_done", done, 0);
    chk("r2_drained", drained, 0);

    // Load and shift together: load wins, then saturate past WIDTH.
    load = 1'b1; shift = 1'b1; d = 8'h3C; cyc();
    chk("ls_q", q, 8'h3C);
    chk("ls_cnt", cnt, 0);
    load = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk($sformatf("sat_cnt%0d", i), cnt, (i > 8) ? 8 : i);
      chk($sformatf("sat_done%0d", i), done, (i == 8) ? 1 : 0);
      chk($sformatf("sat_drn%0d", i), drained, (i >= 8) ? 1 : 0);
    end
    chk("sat_q", q, 8'h00);

    // Reset mid-word: no done pulse anywhere.
    idle(); load = 1'b1; d = 8'hFF; cyc();
    load = 1'b0; shift = 1'b1; dir = 1'b0; si_r = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc(); chk($sformatf("mw_done%0d", i), done, 0);
    end
    chk("mw_q", q, 8'h0F);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mw_rst_q", q, 8'hA5);
    chk("mw_rst_cnt", cnt, 0);
    chk("mw_rst_done", done, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(); chk($sformatf("mw2_done%0d", i), done, 0);
    end
    chk("mw2_cnt", cnt, 4);
    chk("mw2_q", q, 8'h0A);

`ifdef UNIV_SHIFT_ROTATE_EN
    // Rotate right 8 times: word returns, si_r ignored.
    idle(); load = 1'b1; d = 8'h96; cyc();
    load = 1'b0; shift = 1'b1; dir = 1'b0; si_r = 1'b1; rot = 1'b1;
    cyc(); chk("rot1_q", q, 8'h4B);
    for (int i = 2; i <= 8; i++) begin
      cyc(); chk($sformatf("rot_done%0d", i), done, (i == 8) ? 1 : 0);
    end
    chk("rot_q", q, 8'h96);
    chk("rot_drained", drained, 1);
    // Rotate left once: MSB wraps into LSB.
    dir = 1'b1; si_l = 1'b0; cyc();
    chk("rotl_q", q, 8'h2D);
    rot = 1'b0;
`endif

    idle(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
